// File: rtl/async_sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM encoding and the
// byte-lane select helper.
package async_sram_arbiter_pkg;

    localparam int W_SRAM_ADDR = 18;
    localparam int W_SRAM_DATA = 16;

    localparam logic [1:0] BYTE_NONE = 2'b11;
    localparam logic [1:0] BYTE_ALL  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

    // Reads always fetch the full halfword; writes enable only the masked lanes.
    function automatic logic [1:0] lane_sel(input logic write, input logic [1:0] wmask);
        return write ? ~wmask : BYTE_ALL;
    endfunction

endpackage

// File: rtl/async_sram_arbiter_if.sv
// Requester handshakes for both ports plus the split SRAM pin bundle.
// The arbiter is the slave; requesters and the pad/SRAM side are the master.
interface async_sram_arbiter_if #(
    parameter int W_ADDR = 18,
    parameter int W_DATA = 16
);
    logic              p0_req;
    logic              p0_write;
    logic [W_ADDR-1:0] p0_addr;
    logic [W_DATA-1:0] p0_wdata;
    logic [1:0]        p0_wmask;
    logic              p0_gnt;
    logic [W_DATA-1:0] p0_rdata;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_write;
    logic [W_ADDR-1:0] p1_addr;
    logic [W_DATA-1:0] p1_wdata;
    logic [1:0]        p1_wmask;
    logic              p1_gnt;
    logic [W_DATA-1:0] p1_rdata;
    logic              p1_rvalid;

    logic [W_ADDR-1:0] sram_addr;
    logic [W_DATA-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [W_DATA-1:0] sram_dq_in;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic [1:0]        sram_byte_n;

    modport slave (
        input  p0_req, p0_write, p0_addr, p0_wdata, p0_wmask,
        output p0_gnt, p0_rdata, p0_rvalid,
        input  p1_req, p1_write, p1_addr, p1_wdata, p1_wmask,
        output p1_gnt, p1_rdata, p1_rvalid,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_byte_n,
        input  sram_dq_in
    );

    modport master (
        output p0_req, p0_write, p0_addr, p0_wdata, p0_wmask,
        input  p0_gnt, p0_rdata, p0_rvalid,
        output p1_req, p1_write, p1_addr, p1_wdata, p1_wmask,
        input  p1_gnt, p1_rdata, p1_rvalid,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_byte_n,
        output sram_dq_in
    );

endinterface

// File: rtl/async_sram_arbiter_arb_rr2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted port;
// on a tie the other port wins. Reset points at port 1 so port 0 wins first.
module arb_rr2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/async_sram_arbiter.sv
// Two-port arbiter for an external asynchronous 16-bit SRAM: round-robin grant,
// OE/WE strobe sequencing, every SRAM-facing output driven from a flop.
module async_sram_arbiter
    import async_sram_arbiter_pkg::*;
#(
    parameter int W_ADDR      = W_SRAM_ADDR,
    parameter int W_DATA      = W_SRAM_DATA,
    parameter int READ_CYCLES = 1,
    parameter int WE_CYCLES   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    async_sram_arbiter_if.slave bus
);

    localparam logic [1:0] RD_LAST = 2'(READ_CYCLES - 1);
    localparam logic [1:0] WE_LAST = 2'(WE_CYCLES - 1);

    state_t            state_reg;
    logic [1:0]        cnt_reg;
    logic              rd_port_reg;
    logic [W_ADDR-1:0] addr_reg;
    logic [W_DATA-1:0] dq_out_reg;
    logic              dq_oe_reg;
    logic              we_n_reg;
    logic              oe_n_reg;
    logic [1:0]        byte_n_reg;
    logic [W_DATA-1:0] rdata0_reg;
    logic [W_DATA-1:0] rdata1_reg;
    logic [1:0]        rvalid_reg;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              rd_done;
    logic              arb_point;
    logic              advance;
    logic              sel;
    logic              sel_write;
    logic [W_ADDR-1:0] sel_addr;
    logic [W_DATA-1:0] sel_wdata;
    logic [1:0]        sel_wmask;

    assign req       = {bus.p1_req, bus.p0_req};
    assign rd_done   = (state_reg == ST_RD) && (cnt_reg == RD_LAST);
    // A new access may start from idle or overlap the last cycle of a read.
    assign arb_point = (state_reg == ST_IDLE) || rd_done;
    assign advance   = arb_point && (req != 2'b00);

    arb_rr2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign sel       = grant[1];
    assign sel_write = sel ? bus.p1_write : bus.p0_write;
    assign sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
    assign sel_wmask = sel ? bus.p1_wmask : bus.p0_wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rd_port_reg <= 1'b0;
            addr_reg    <= '0;
            dq_out_reg  <= '0;
            dq_oe_reg   <= 1'b0;
            we_n_reg    <= 1'b1;
            oe_n_reg    <= 1'b1;
            byte_n_reg  <= BYTE_NONE;
            rdata0_reg  <= '0;
            rdata1_reg  <= '0;
            rvalid_reg  <= 2'b00;
        end else begin
            rvalid_reg <= 2'b00;
            if (rd_done) begin
                if (rd_port_reg) begin
                    rdata1_reg <= bus.sram_dq_in;
                    rvalid_reg <= 2'b10;
                end else begin
                    rdata0_reg <= bus.sram_dq_in;
                    rvalid_reg <= 2'b01;
                end
            end

            case (state_reg)
                ST_IDLE, ST_RD: begin
                    if (state_reg == ST_RD && !rd_done) begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end else if (advance) begin
                        addr_reg    <= sel_addr;
                        byte_n_reg  <= lane_sel(sel_write, sel_wmask);
                        cnt_reg     <= '0;
                        rd_port_reg <= sel;
                        if (sel_write) begin
                            // Read-to-write: OE releases on the same edge the driver turns on.
                            state_reg  <= ST_WR_SETUP;
                            dq_out_reg <= sel_wdata;
                            dq_oe_reg  <= 1'b1;
                            oe_n_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_RD;
                            oe_n_reg  <= 1'b0;
                        end
                    end else begin
                        state_reg  <= ST_IDLE;
                        oe_n_reg   <= 1'b1;
                        byte_n_reg <= BYTE_NONE;
                    end
                end
                ST_WR_SETUP: begin
                    state_reg <= ST_WR_PULSE;
                    we_n_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
                ST_WR_PULSE: begin
                    if (cnt_reg == WE_LAST) begin
                        state_reg <= ST_WR_HOLD;
                        we_n_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
                ST_WR_HOLD: begin
                    // Always drop to idle so a following read sees the bus released.
                    state_reg  <= ST_IDLE;
                    dq_oe_reg  <= 1'b0;
                    byte_n_reg <= BYTE_NONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_gnt      = arb_point & grant[0];
    assign bus.p1_gnt      = arb_point & grant[1];
    assign bus.p0_rdata    = rdata0_reg;
    assign bus.p1_rdata    = rdata1_reg;
    assign bus.p0_rvalid   = rvalid_reg[0];
    assign bus.p1_rvalid   = rvalid_reg[1];
    assign bus.sram_addr   = addr_reg;
    assign bus.sram_dq_out = dq_out_reg;
    assign bus.sram_dq_oe  = dq_oe_reg;
    assign bus.sram_we_n   = we_n_reg;
    assign bus.sram_oe_n   = oe_n_reg;
    assign bus.sram_byte_n = byte_n_reg;

endmodule

// File: doc/async_sram_arbiter.md
Name: async_sram_arbiter

Overview:
Shares the single external 16-bit asynchronous SRAM (18-bit halfword address, active-low WE/OE/byte lanes, CE tied low on board) between two requesters: port 0 is the processor and port 1 is the display/DMA.
- Arbitrates round-robin and sequences the SRAM read and write strobe timing.
- Presents split dq_out/dq_oe/dq_in signals; the top-level tristate pad instances join these to the inout bus.
- All SRAM-facing outputs are registered, so no glitches reach the pins.

Parameters:
W_ADDR, 18, SRAM halfword address width
W_DATA, 16, SRAM data width (fixed at 16; byte lanes assume 2)
READ_CYCLES, 1, number of cycles OE_n is held low per read (1..4)
WE_CYCLES, 1, number of cycles WE_n is held low per write (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pN_req  in  1  port N (N=0,1) request; held stable until pN_gnt
pN_write  in  1  1 = write, 0 = read
pN_addr  in  W_ADDR  halfword address
pN_wdata  in  W_DATA  write data
pN_wmask  in  2  byte enables, bit1 = upper byte
pN_gnt  out  1  one-cycle pulse: request accepted; writes are posted, so this completes them
pN_rdata  out  W_DATA  read data, valid with pN_rvalid
pN_rvalid  out  1  one-cycle read-data-valid pulse
sram_addr  out  W_ADDR  SRAM address
sram_dq_out  out  W_DATA  data to drive onto the SRAM bus
sram_dq_oe  out  1  drive enable for sram_dq
sram_dq_in  in  W_DATA  sampled SRAM bus
sram_we_n  out  1  write strobe
sram_oe_n  out  1  output enable
sram_byte_n  out  2  active-low byte lane selects

Behaviour:
- Reset values:
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, sram_byte_n=2'b11.
  - pN_gnt=0, pN_rvalid=0, pN_rdata=0.
  - FSM=IDLE, last-granted pointer=1, so port 0 wins the first tie.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration points: in IDLE, and in the final RD cycle.
  - If one request is present, grant it.
  - If both are present, grant the port that was not granted last.
  - Update the pointer on every grant.
- Grant: pN_gnt pulses in the arbitration cycle. The chosen port's addr, write and wdata are latched, and byte_n is set to ~wmask on the same edge.
- Read:
  - RD lasts READ_CYCLES cycles with oe_n=0, dq_oe=0 and byte_n=2'b00.
  - sram_dq_in is registered into pN_rdata at the end of the last RD cycle.
  - pN_rvalid=1 in the following cycle.
  - Latency with READ_CYCLES=1: gnt at cycle T, oe_n low at T+1, rvalid at T+2.
  - Back-to-back reads sustain one read per READ_CYCLES cycles, with oe_n held low continuously and only addr changing.
- Write:
  - WR_SETUP, 1 cycle: addr, byte_n and dq_out valid; dq_oe=1; we_n=1.
  - WR_PULSE, WE_CYCLES cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, dq still driven.
  - Then IDLE with dq_oe=0. Arbitration is never performed in write states.
- Bus turnaround: a read following a write always passes through IDLE, so dq_oe=0 for at least one cycle before oe_n falls. dq_oe and oe_n low are never asserted together.
- A write with wmask=2'b00 runs the full sequence with byte_n=2'b11, so the SRAM content is unchanged.
- Ungranted requests wait indefinitely. Round-robin bounds the wait to one foreign transaction.
- A requester must not change request fields while req=1 and gnt=0; behaviour in that case is undefined.
- Reset asserted mid-transaction: all outputs return to reset values immediately, the in-flight access is abandoned, and no rvalid is issued.

Decomposition:
- Shared package/header (sram_defs.vh) holds:
  - W_SRAM_ADDR=18 and W_SRAM_DATA=16, also used by riscboy_core top wiring;
  - FSM state encodings.
- One sub-module: arb_rr2, a 2-way round-robin arbiter with registered last-grant pointer, inputs req[1:0] and advance, output one-hot grant.

Test Plan:
- Reset then p0 read addr 0x00010, SRAM model returns 0xBEEF -> p0_gnt at T, oe_n low only at T+1, p0_rdata=0xBEEF with p0_rvalid at T+2; all strobes at reset values before T.
- p1 write addr 0x3FFFF data 0x1234 mask 2'b01 -> byte_n=2'b10; we_n low exactly 1 cycle with dq_oe=1 in setup/pulse/hold; model upper byte unchanged.
- p0 and p1 both requesting continuous reads -> grants alternate 0,1,0,1 (port 0 first); oe_n stays low; rvalids return in grant order.
- Write immediately followed by read on the other port -> at least one cycle with dq_oe=0 and oe_n=1 between WR_HOLD and RD; assertion that dq_oe&&!oe_n never holds.
- READ_CYCLES=3, WE_CYCLES=2 build -> oe_n low 3 cycles, rvalid at T+4; we_n low exactly 2 cycles.
- rst_n low during WR_PULSE -> we_n=1, dq_oe=0 asynchronously; after release, no gnt or rvalid until a new request arrives.
